// File: rtl/soc_sram_wb_adapter_if.sv
// rtl/soc_sram_wb_adapter_if.sv - Wishbone B3 bus bundle between a master and the SRAM adapter
interface soc_sram_wb_adapter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  localparam int SW = DW / 8;

  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [SW-1:0] wb_sel_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;
  logic [DW-1:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_bte_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_bte_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );
endinterface

// File: rtl/soc_sram_wb_adapter.sv
// rtl/soc_sram_wb_adapter.sv - Wishbone B3 slave driving a single-port SRAM with registered read data
module soc_sram_wb_adapter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MEM_SIZE_BYTE = 32768,
  localparam int SW           = DW / 8,
  localparam int WORD_AW      = AW - (SW >> 1)
) (
  input  logic                clk,
  input  logic                rst,
  soc_sram_wb_adapter_if.slave wb,
  output logic                sram_ce,
  output logic                sram_we,
  output logic                sram_oe,
  output logic [WORD_AW-1:0]  sram_waddr,
  output logic [DW-1:0]       sram_din,
  output logic [SW-1:0]       sram_sel,
  input  logic [DW-1:0]       sram_dout
);
  localparam int AB = SW >> 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

  state_t               state_q, state_d;
  logic [WORD_AW-1:0]   adr_q, adr_d;
  logic [WORD_AW-1:0]   wa, nxt, wrap_mask;
  logic                 req, oor_wa, oor_nxt;
  logic                 ack, err;
  logic [DW-1:0]        dat_o;
  logic                 unused_adr;

  function automatic logic out_of_range(input logic [WORD_AW-1:0] w);
    logic [63:0] byte_adr;
    byte_adr = 64'(w) << AB;
    return byte_adr >= 64'(MEM_SIZE_BYTE);
  endfunction

  assign req        = wb.wb_cyc_i & wb.wb_stb_i;
  assign wa         = wb.wb_adr_i[AW-1:AB];
  assign unused_adr = ^wb.wb_adr_i;
  assign oor_wa     = out_of_range(wa);

  // Wrap bursts only advance the low bits; linear bursts use a full-width mask.
  always_comb begin
    wrap_mask = '1;
    case (wb.wb_bte_i)
      2'b01:   wrap_mask = WORD_AW'(3);
      2'b10:   wrap_mask = WORD_AW'(7);
      2'b11:   wrap_mask = WORD_AW'(15);
      default: wrap_mask = '1;
    endcase
    nxt = (adr_q & ~wrap_mask) | ((adr_q + WORD_AW'(1)) & wrap_mask);
  end

  assign oor_nxt = out_of_range(nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    ack        = 1'b0;
    err        = 1'b0;
    dat_o      = '0;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_waddr = wa;
    sram_din   = wb.wb_dat_i;
    sram_sel   = '1;
    case (state_q)
      IDLE: begin
        // Prefetch read of the requested word; a write simply ignores the data.
        sram_ce = req;
        if (req) begin
          if (oor_wa) begin
            state_d = ERR;
          end else begin
            adr_d   = wa;
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        ack     = req;
        sram_ce = req;
        if (wb.wb_we_i) begin
          sram_we    = req;
          sram_waddr = adr_q;
          sram_sel   = wb.wb_sel_i;
        end else begin
          sram_waddr = nxt;
          if (req) dat_o = sram_dout;
        end
        if (req && wb.wb_cti_i == 3'b010) begin
          if (oor_nxt) begin
            state_d = ERR;
          end else begin
            adr_d   = nxt;
            state_d = ACTIVE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ERR: begin
        err     = req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sram_oe     = sram_ce & ~sram_we;
  assign wb.wb_ack_o = ack;
  assign wb.wb_err_o = err;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = dat_o;
endmodule

// File: tb/tb_soc_sram_wb_adapter.sv
// tb/tb_soc_sram_wb_adapter.sv - scoreboard bench for the Wishbone SRAM adapter
module tb_soc_sram_wb_adapter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_ce, sram_we, sram_oe;
  logic [29:0] sram_waddr;
  logic [31:0] sram_din;
  logic [3:0]  sram_sel;
  logic [31:0] sram_dout = 32'h0;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int bad_wr = 0;

  typedef struct packed {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:8191];

  soc_sram_wb_adapter_if #(.AW(32), .DW(32)) b ();

  soc_sram_wb_adapter #(.AW(32), .DW(32), .MEM_SIZE_BYTE(32768)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (b),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_oe    (sram_oe),
    .sram_waddr (sram_waddr),
    .sram_din   (sram_din),
    .sram_sel   (sram_sel),
    .sram_dout  (sram_dout)
  );

  always #5 clk = ~clk;

  // SRAM macro model: byte-masked write, registered read with one-cycle latency.
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        if (sram_waddr < 30'd8192) begin
          for (int i = 0; i < 4; i++)
            if (sram_sel[i]) mem[sram_waddr[12:0]][8*i +: 8] <= sram_din[8*i +: 8];
        end else begin
          bad_wr <= bad_wr + 1;
        end
      end else begin
        sram_dout <= (sram_waddr < 30'd8192) ? mem[sram_waddr[12:0]] : 32'hBAD0BAD0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sram_oe !== (sram_ce & ~sram_we)) viol++;
    if (!b.wb_ack_o && b.wb_dat_o !== 32'h0) viol++;
    if (b.wb_rty_o !== 1'b0) viol++;
    if (sram_we && !b.wb_ack_o) viol++;
    if (b.wb_ack_o || b.wb_err_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_term", {30'h0, b.wb_ack_o, b.wb_err_o}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("term_kind", {30'h0, b.wb_ack_o, b.wb_err_o}, {30'h0, ~e.is_err, e.is_err});
        if (e.chk_dat) chk("read_data", b.wb_dat_o, e.dat);
      end
    end
  end

  task automatic idle_bus();
    b.wb_cyc_i = 1'b0; b.wb_stb_i = 1'b0; b.wb_we_i = 1'b0;
    b.wb_adr_i = '0;   b.wb_dat_i = '0;   b.wb_sel_i = '0;
    b.wb_cti_i = '0;   b.wb_bte_i = '0;
  endtask

  // Presents one beat (caller is just past a rising edge), waits for its termination.
  task automatic beat(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte,
                      input int lat, input logic e_err, input logic e_chk,
                      input logic [31:0] e_dat, input logic last);
    int n;
    sb.push_back('{is_err: e_err, chk_dat: e_chk, dat: e_dat});
    b.wb_cyc_i = 1'b1; b.wb_stb_i = 1'b1; b.wb_we_i = we;
    b.wb_adr_i = adr;  b.wb_dat_i = dat;  b.wb_sel_i = sel;
    b.wb_cti_i = cti;  b.wb_bte_i = bte;
    n = 0;
    @(negedge clk);
    while (!(b.wb_ack_o || b.wb_err_o) && n < 16) begin
      n++;
      @(negedge clk);
    end
    chk("latency", n, lat);
    @(posedge clk); #1;
    if (last) idle_bus();
  endtask

  task automatic classic_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    @(posedge clk); #1;
    beat(1'b1, adr, dat, sel, 3'b000, 2'b00, 1, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic classic_rd(input logic [31:0] adr, input logic [31:0] expd);
    @(posedge clk); #1;
    beat(1'b0, adr, 32'h0, 4'hf, 3'b000, 2'b00, 1, 1'b0, 1'b1, expd, 1'b1);
  endtask

  initial begin
    idle_bus();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b.wb_cyc_i = 1'b1; b.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ack", {31'h0, b.wb_ack_o}, 32'h0);
    chk("rst_err", {31'h0, b.wb_err_o}, 32'h0);
    chk("rst_we", {31'h0, sram_we}, 32'h0);
    chk("rst_ce", {31'h0, sram_ce}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_bus();

    // Classic write/read.
    classic_wr(32'h10, 32'hDEADBEEF, 4'hf);
    classic_rd(32'h10, 32'hDEADBEEF);

    // Byte-select write.
    classic_wr(32'h20, 32'h11223344, 4'hf);
    classic_wr(32'h20, 32'h000000AA, 4'b0001);
    classic_rd(32'h20, 32'h112233AA);

    // Preload words 0x40..0x47 with 0..7, and word 0xC2 with zero.
    for (int i = 0; i < 8; i++) classic_wr(32'h100 + 32'(4 * i), 32'(i), 4'hf);
    classic_wr(32'h308, 32'h0, 4'hf);

    // Linear 4-beat read burst.
    @(posedge clk); #1;
    beat(1'b0, 32'h100, 32'h0, 4'hf, 3'b010, 2'b00, 1, 1'b0, 1'b1, 32'd0, 1'b0);
    beat(1'b0, 32'h104, 32'h0, 4'hf, 3'b010, 2'b00, 0, 1'b0, 1'b1, 32'd1, 1'b0);
    beat(1'b0, 32'h108, 32'h0, 4'hf, 3'b010, 2'b00, 0, 1'b0, 1'b1, 32'd2, 1'b0);
    beat(1'b0, 32'h10C, 32'h0, 4'hf, 3'b111, 2'b00, 0, 1'b0, 1'b1, 32'd3, 1'b1);

    // Wrap-8 read burst from word 0x46: 0x46, 0x47, 0x40.
    @(posedge clk); #1;
    beat(1'b0, 32'h118, 32'h0, 4'hf, 3'b010, 2'b10, 1, 1'b0, 1'b1, 32'd6, 1'b0);
    beat(1'b0, 32'h11C, 32'h0, 4'hf, 3'b010, 2'b10, 0, 1'b0, 1'b1, 32'd7, 1'b0);
    beat(1'b0, 32'h100, 32'h0, 4'hf, 3'b111, 2'b10, 0, 1'b0, 1'b1, 32'd0, 1'b1);

    // Wrap-4 write burst from word 6: words 6, 7, 4, 5.
    @(posedge clk); #1;
    beat(1'b1, 32'h18, 32'hAAAA000A, 4'hf, 3'b010, 2'b01, 1, 1'b0, 1'b0, 32'h0, 1'b0);
    beat(1'b1, 32'h1C, 32'hBBBB000B, 4'hf, 3'b010, 2'b01, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    beat(1'b1, 32'h10, 32'hCCCC000C, 4'hf, 3'b010, 2'b01, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    beat(1'b1, 32'h14, 32'hDDDD000D, 4'hf, 3'b111, 2'b01, 0, 1'b0, 1'b0, 32'h0, 1'b1);
    classic_rd(32'h18, 32'hAAAA000A);
    classic_rd(32'h1C, 32'hBBBB000B);
    classic_rd(32'h10, 32'hCCCC000C);
    classic_rd(32'h14, 32'hDDDD000D);

    // Out-of-range classic write and read.
    @(posedge clk); #1;
    beat(1'b1, 32'h8000, 32'h12345678, 4'hf, 3'b000, 2'b00, 1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    beat(1'b0, 32'h8000, 32'h0, 4'hf, 3'b000, 2'b00, 1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Linear burst from word 0x1FFE errors on its third beat.
    @(posedge clk); #1;
    beat(1'b1, 32'h7FF8, 32'h0BAD0001, 4'hf, 3'b010, 2'b00, 1, 1'b0, 1'b0, 32'h0, 1'b0);
    beat(1'b1, 32'h7FFC, 32'h0BAD0002, 4'hf, 3'b010, 2'b00, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    beat(1'b1, 32'h8000, 32'h0BAD0003, 4'hf, 3'b010, 2'b00, 0, 1'b1, 1'b0, 32'h0, 1'b1);
    classic_rd(32'h7FF8, 32'h0BAD0001);
    classic_rd(32'h7FFC, 32'h0BAD0002);

    // Reset during the second beat of a write burst.
    @(posedge clk); #1;
    beat(1'b1, 32'h300, 32'h5A5A0001, 4'hf, 3'b010, 2'b00, 1, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    beat(1'b1, 32'h304, 32'h5A5A0002, 4'hf, 3'b010, 2'b00, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    b.wb_adr_i = 32'h308; b.wb_dat_i = 32'h5A5A0003; b.wb_cti_i = 3'b010;
    @(negedge clk);
    chk("post_rst_ack", {31'h0, b.wb_ack_o}, 32'h0);
    chk("post_rst_we", {31'h0, sram_we}, 32'h0);
    @(posedge clk); #1;
    idle_bus();
    classic_rd(32'h300, 32'h5A5A0001);
    classic_rd(32'h308, 32'h0);

    repeat (4) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    chk("protocol_viol", 32'(viol), 32'h0);
    chk("oor_sram_write", 32'(bad_wr), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/soc_sram_wb_adapter.md
# soc_sram_wb_adapter

Wishbone B3 slave that sits directly upstream of the plain single-port SRAM macro and turns bus cycles into SRAM `ce/we/oe/waddr/din/sel` strobes. It consumes the SRAM's registered read data (one-cycle latency) and returns it on the bus. Classic cycles take two clocks per beat. Incrementing bursts (linear and wrap-4/8/16) sustain one beat per clock. Out-of-range accesses are terminated with an error.

## Interface
- `AW`, 32, byte address width
- `DW`, 32, data width (8, 16 or 32)
- `SW`, derived: 4/2/1 for DW 32/16/8, byte-select width
- `WORD_AW`, `AW-(SW>>1)`, SRAM word address width
- `MEM_SIZE_BYTE`, 32768, memory size in bytes; accesses at or above this are errors
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: reset, synchronous, active-high
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` in 1 each: Wishbone cycle, strobe and write enable
- `wb_adr_i` in AW: byte address; bits [SW>>1 -1:0] are ignored
- `wb_dat_i` in DW, `wb_sel_i` in SW: write data and byte selects
- `wb_cti_i` in 3, `wb_bte_i` in 2: cycle type and burst type
- `wb_ack_o`, `wb_err_o`, `wb_rty_o` out 1 each: termination signals; `wb_rty_o` is tied to 0
- `wb_dat_o` out DW: read data
- `sram_ce`, `sram_we`, `sram_oe` out 1 each: SRAM chip enable, write enable, output enable
- `sram_waddr` out WORD_AW: SRAM word address
- `sram_din` out DW, `sram_sel` out SW: SRAM write data and byte selects
- `sram_dout` in DW: SRAM read data, valid the cycle after its address was presented

## Operation
- Request: `req = wb_cyc_i & wb_stb_i`. Word address: `wa = wb_adr_i[AW-1:SW>>1]`. Range check: `oor = (wa*SW >= MEM_SIZE_BYTE)`.
- States are IDLE, ACTIVE and ERR. Registered state: `adr_q[WORD_AW]`, the current beat address.
- IDLE:
  - `sram_waddr = wa`, `sram_ce = req`, `sram_we = 0`. This is a read prefetch and is harmless for writes.
  - On `req & !oor`: `adr_q <= wa`, go to ACTIVE.
  - On `req & oor`: go to ERR.
- ACTIVE:
  - `wb_ack_o = req`.
  - Write (`wb_we_i`): `sram_we = req`, `sram_waddr = adr_q`, `sram_din = wb_dat_i`, `sram_sel = wb_sel_i`.
  - Read: `wb_dat_o = sram_dout` (data for `adr_q`). `sram_waddr = nxt` (prefetch of the next beat).
  - Continue condition: `req & wb_cti_i==3'b010`.
    - If continuing and `nxt` is in range: `adr_q <= nxt`, stay in ACTIVE.
    - If continuing and `nxt` is out of range: go to ERR.
    - Otherwise (CTI 000, 111, any reserved value, or `req` low): go to IDLE.
- ERR: `wb_err_o = req`, no SRAM write, then go to IDLE.
- Next-address arithmetic, `nxt` from `adr_q`:
  - BTE 00: `adr_q+1` mod 2^WORD_AW.
  - BTE 01, 10, 11: low 2, 3 or 4 bits incremented modulo 4, 8 or 16; upper bits unchanged.
- `sram_oe = sram_ce & !sram_we`. `sram_sel` is all-ones on reads. `wb_dat_o` is 0 whenever `wb_ack_o` is 0.
- `wb_we_i` changing mid-burst is unsupported; no check is made.

## Timing
- Reset: state IDLE, `adr_q=0`.
- Every output is combinational from the registered state and the inputs. When `rst` is sampled high, the following cycle has `wb_ack_o=0`, `wb_err_o=0`, `sram_we=0`, `sram_ce` = IDLE value.
- Classic read or write: strobe in cycle N, ack in cycle N+1. A write lands in the SRAM at the rising edge ending N+1. Throughput is 2 cycles per beat.
- Burst: first ack at N+1, then one ack per cycle while CTI=010. The beat flagged CTI=111 is acked and the block returns to IDLE.
- Master abort: if `wb_cyc_i` or `wb_stb_i` drops in ACTIVE, there is no ack and no SRAM write in that cycle; the next state is IDLE.
- Reset mid-burst: no ack and no write after the reset edge; the burst is lost.
- Error latency equals ack latency (one cycle after the strobe or the previous beat).

## Test plan
- Classic write 0xDEADBEEF to byte address 0x10 (sel=1111), then classic read of 0x10: each ack comes exactly 1 cycle after the strobe, and the read returns 0xDEADBEEF.
- Byte-select write 0x000000AA with sel=0001 over 0x11223344 at 0x20, then read: returns 0x112233AA.
- Linear read burst of 4 beats from 0x100, CTI 010,010,010,111, memory preloaded with 0..3 at words 0x40–0x43: acks on 4 consecutive cycles, data 0,1,2,3, then IDLE.
- Wrap-4 write burst starting at word 6 (BTE=01), data A,B,C,D: written to words 6,7,4,5 respectively; verified by readback.
- With MEM_SIZE_BYTE=32768: classic access to 0x8000 gives `wb_err_o` one cycle later with no ack and no SRAM write. A linear burst starting at word 0x1FFE errors on its third beat.
- Reset asserted during the 2nd beat of a write burst: no further `sram_we` after reset, `wb_ack_o=0`. A following classic read works normally.
